spi_reg_responder: RTL and testbench
====================================

Name: spi_reg_responder

Overview:
- SPI mode-0 responder (slave) that gives the DSP or CPU SPI master register access inside the CPLD.
- It is the target-side counterpart of the sequencer's PLL SPI initiator. It is instantiated once per host SPI bank (dsp_spi_*, cpu_spi*_1v8_*).
- The block exposes a bank of read/write control bytes (LED overrides, UART routing selects, reset requests) and a bank of read-only status bytes (power-good and sequencer state).
- All SPI inputs are oversampled on sysclk, which is the internal oscillator at 3.3-5.5 MHz. The SPI clock must therefore be at most sysclk/8.

Parameters:
- NUM_CTRL, 4: number of read/write control bytes, at addresses 0..NUM_CTRL-1. Range 1..16.
- CTRL_RESET, 0: reset value of the control bus, 8*NUM_CTRL bits.
- NUM_STAT, 4: number of read-only status bytes, at addresses STAT_BASE..STAT_BASE+NUM_STAT-1. Range 1..16.
- STAT_BASE, 7'h40: base address of the status bank.
- ID_VALUE, 8'hC5: value returned when address 7'h7F is read.

Ports:
- sysclk  in  1  system clock.
- reset_INV  in  1  asynchronous active-low reset.
- spi_clk  in  1  SPI SCLK from the host; idles low (mode 0).
- spi_mosi  in  1  host data in; sampled on SCLK rise.
- spi_cs_INV  in  1  active-low chip select.
- spi_miso  out  1  data to the host; changes on SCLK fall.
- stat  in  8*NUM_STAT  status inputs; byte k is at STAT_BASE+k.
- ctrl  out  8*NUM_CTRL  control registers; byte k is at address k.
- wr_strobe  out  1  one-cycle pulse when a control byte is updated.
- wr_addr  out  7  address of the last accepted write.
- frame_err  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset (asynchronous, reset_INV=0):
  - ctrl=CTRL_RESET, spi_miso=0, wr_strobe=0, wr_addr=0, frame_err=0.
  - Bit counter=0, synchronizers cleared to the idle state (cs=1, sclk=0).
- Input synchronisation: spi_clk, spi_mosi and spi_cs_INV each pass through a 2-flop synchronizer. SCLK rise and fall are detected by comparing the synced value with its previous value.
- Frame format: 16 bits, MSB first.
  - Bit 15 = R/W (1 = read).
  - Bits 14:8 = address.
  - Bits 7:0 = write data (ignored on reads).
- States:
  - IDLE: waiting for a cs falling edge.
  - CMD: bits 15..8 being received.
  - DATA: bits 7..0 being received or transmitted.
  - DONE: 16 bits received; waiting for cs to rise.
- Transitions:
  - IDLE->CMD on synced cs falling. The bit counter is cleared.
  - CMD->DATA on the 8th SCLK rise. At this point the address is latched and the read byte is snapshotted into the TX shift register:
    - control byte if address < NUM_CTRL;
    - stat byte if the address is in the status window;
    - ID_VALUE if address = 7'h7F;
    - 8'h00 otherwise.
  - DATA->DONE on the 16th SCLK rise.
  - Any state->IDLE on synced cs high.
- MISO timing:
  - spi_miso=0 throughout CMD.
  - On the 8th SCLK fall, spi_miso drives TX bit 7. Each subsequent fall shifts out the next bit.
  - spi_miso returns to 0 in DONE and IDLE.
- Write commit: on entering DONE with R/W=0 and address < NUM_CTRL:
  - ctrl byte[address] is updated on the next sysclk edge;
  - wr_addr=address and wr_strobe=1 for exactly one cycle.
- Write boundary cases:
  - Writes to the status window, 7'h7F or unmapped addresses are silently dropped: no wr_strobe, ctrl unchanged.
  - A read of a control byte has no side effects.
- Abort: cs rising while in CMD or DATA (fewer than 16 bits received):
  - the frame is discarded, ctrl is unchanged, no wr_strobe;
  - frame_err=1 for one cycle; return to IDLE.
- Overlong frame: SCLK edges in DONE are ignored. spi_miso stays 0, no second transaction occurs, and no frame_err is raised.
- Simultaneous events: if cs rise and the 16th SCLK rise are detected in the same sysclk cycle, the frame completes (commit first), then the block goes to IDLE. frame_err is not raised.
- Back-to-back frames require cs to be high for at least 3 sysclk cycles between frames. A shorter gap is missed and is treated as one continuous frame.
- Reset mid-frame: everything returns to reset values immediately. The next frame is decoded only after a fresh cs falling edge.
- Latency: from a pin SCLK rise to the sampled bit is 3 sysclk cycles. ctrl updates 1 cycle after the DONE entry.

Test Plan:
- Write 0x02,0xA5 with NUM_CTRL=4: ctrl[23:16]=8'hA5, wr_strobe pulses once, wr_addr=2; other bytes keep CTRL_RESET.
- Write 0x02 then read 0x82: MISO returns 8'hA5 in bits 7:0; all 8 command-phase bits read 0; ctrl unchanged, no wr_strobe.
- Read 0xC1 (address 0x41) with stat byte1=8'h3C: MISO=8'h3C. Read 0xFF: MISO=8'hC5. Read 0x90 (unmapped): MISO=8'h00.
- Write 0x41,0x55: no wr_strobe, stat unaffected; subsequent reads of control bytes are unchanged.
- Raise cs after 11 bits of a write to address 0: frame_err pulses once, ctrl[7:0] unchanged. The next full frame (write 0x00,0x0F) sets ctrl[7:0]=8'h0F.
- Assert reset_INV=0 mid-frame, then release: all outputs equal their reset values. A 20-bit frame (write 0x01,0x33 plus 4 extra clocks) gives ctrl[15:8]=8'h33, a single wr_strobe, and no frame_err.

Source files
------------

// File: rtl/spi_reg_responder.sv
// rtl/spi_reg_responder.sv - SPI mode-0 register responder with control and status byte banks
module spi_reg_responder #(
    parameter int                     NUM_CTRL   = 4,
    parameter logic [8*NUM_CTRL-1:0]  CTRL_RESET = '0,
    parameter int                     NUM_STAT   = 4,
    parameter logic [6:0]             STAT_BASE  = 7'h40,
    parameter logic [7:0]             ID_VALUE   = 8'hC5
) (
    input  logic                    sysclk,
    input  logic                    reset_INV,
    input  logic                    spi_clk,
    input  logic                    spi_mosi,
    input  logic                    spi_cs_INV,
    output logic                    spi_miso,
    input  logic [8*NUM_STAT-1:0]   stat,
    output logic [8*NUM_CTRL-1:0]   ctrl,
    output logic                    wr_strobe,
    output logic [6:0]              wr_addr,
    output logic                    frame_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [7:0] NUM_CTRL_W = 8'(NUM_CTRL);

    logic cs_meta_q, cs_sync_q, cs_prev_q;
    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic mosi_meta_q, mosi_sync_q;

    logic [1:0]              state_q, state_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic [6:0]              cmd_sr_q, cmd_sr_d;
    logic [6:0]              data_sr_q, data_sr_d;
    logic                    rw_q, rw_d;
    logic [6:0]              addr_q, addr_d;
    logic [7:0]              tx_sr_q, tx_sr_d;
    logic                    miso_q, miso_d;
    logic                    commit_q, commit_d;
    logic [7:0]              wdata_q, wdata_d;
    logic [8*NUM_CTRL-1:0]   ctrl_q, ctrl_d;
    logic                    wr_strobe_q, wr_strobe_d;
    logic [6:0]              wr_addr_q, wr_addr_d;
    logic                    frame_err_q, frame_err_d;

    logic       sclk_rise, sclk_fall, cs_fall, last_rise, addr_is_ctrl;
    logic [6:0] cmd_addr;
    logic [7:0] rd_byte;

    // Two-flop synchronizers; the extra prev flops give edge detection on the synced values
    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            cs_meta_q   <= spi_cs_INV;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            sclk_meta_q <= spi_clk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            mosi_meta_q <= spi_mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    assign sclk_rise    = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall    = ~sclk_sync_q & sclk_prev_q;
    assign cs_fall      = ~cs_sync_q & cs_prev_q;
    assign last_rise    = sclk_rise && (bit_cnt_q == 4'd15);
    assign cmd_addr     = {cmd_sr_q[5:0], mosi_sync_q};
    assign addr_is_ctrl = ({1'b0, addr_q} < NUM_CTRL_W);

    // Read byte for the address completing on the 8th rise; control bank wins any overlap
    always_comb begin
        rd_byte = 8'h00;
        if (cmd_addr == 7'h7F) rd_byte = ID_VALUE;
        for (int k = 0; k < NUM_STAT; k++) begin
            if (cmd_addr == STAT_BASE + 7'(k)) rd_byte = stat[8*k +: 8];
        end
        for (int k = 0; k < NUM_CTRL; k++) begin
            if (cmd_addr == 7'(k)) rd_byte = ctrl_q[8*k +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        cmd_sr_d    = cmd_sr_q;
        data_sr_d   = data_sr_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        tx_sr_d     = tx_sr_q;
        miso_d      = miso_q;
        commit_d    = 1'b0;
        wdata_d     = wdata_q;
        ctrl_d      = ctrl_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        frame_err_d = 1'b0;

        if (commit_q) begin
            for (int k = 0; k < NUM_CTRL; k++) begin
                if (addr_q == 7'(k)) ctrl_d[8*k +: 8] = wdata_q;
            end
            wr_strobe_d = 1'b1;
            wr_addr_d   = addr_q;
        end

        case (state_q)
            S_IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d   = S_CMD;
                    bit_cnt_d = 4'd0;
                end
            end
            S_CMD: begin
                miso_d = 1'b0;
                if (sclk_rise) begin
                    cmd_sr_d  = {cmd_sr_q[5:0], mosi_sync_q};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        rw_d    = cmd_sr_q[6];
                        addr_d  = cmd_addr;
                        tx_sr_d = rd_byte;
                        state_d = S_DATA;
                    end
                end
                if (cs_sync_q) begin
                    state_d     = S_IDLE;
                    frame_err_d = 1'b1;
                end
            end
            S_DATA: begin
                if (sclk_fall) begin
                    miso_d  = tx_sr_q[7];
                    tx_sr_d = {tx_sr_q[6:0], 1'b0};
                end
                if (sclk_rise) begin
                    data_sr_d = {data_sr_q[5:0], mosi_sync_q};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                if (last_rise) begin
                    state_d = S_DONE;
                    miso_d  = 1'b0;
                    if (!rw_q && addr_is_ctrl) begin
                        commit_d = 1'b1;
                        wdata_d  = {data_sr_q, mosi_sync_q};
                    end
                end
                // A cs rise coinciding with the 16th rise still lets the frame commit
                if (cs_sync_q) begin
                    state_d = S_IDLE;
                    miso_d  = 1'b0;
                    if (!last_rise) frame_err_d = 1'b1;
                end
            end
            S_DONE: begin
                miso_d = 1'b0;
                if (cs_sync_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 4'd0;
            cmd_sr_q    <= 7'd0;
            data_sr_q   <= 7'd0;
            rw_q        <= 1'b0;
            addr_q      <= 7'd0;
            tx_sr_q     <= 8'd0;
            miso_q      <= 1'b0;
            commit_q    <= 1'b0;
            wdata_q     <= 8'd0;
            ctrl_q      <= CTRL_RESET;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 7'd0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_sr_q    <= cmd_sr_d;
            data_sr_q   <= data_sr_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            tx_sr_q     <= tx_sr_d;
            miso_q      <= miso_d;
            commit_q    <= commit_d;
            wdata_q     <= wdata_d;
            ctrl_q      <= ctrl_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign spi_miso  = miso_q;
    assign ctrl      = ctrl_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_reg_responder.sv
// tb/tb_spi_reg_responder.sv - directed self-checking bench for spi_reg_responder
`timescale 1ns/1ps
module tb_spi_reg_responder;

    localparam int HALF = 80;
    localparam int GAP  = 200;

    logic        sysclk = 1'b0;
    logic        reset_INV = 1'b0;
    logic        spi_clk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_cs_INV = 1'b1;
    logic        spi_miso;
    logic [31:0] stat = 32'hA5_96_3C_81;
    logic [31:0] ctrl;
    logic        wr_strobe;
    logic [6:0]  wr_addr;
    logic        frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int ws_cnt   = 0;
    int fe_cnt   = 0;
    int ws0, fe0;
    logic [7:0] cmd_rx, dat_rx;
    logic [3:0] ext_rx;

    spi_reg_responder #(
        .NUM_CTRL(4), .CTRL_RESET(32'h44_33_22_11), .NUM_STAT(4),
        .STAT_BASE(7'h40), .ID_VALUE(8'hC5)
    ) dut (
        .sysclk(sysclk), .reset_INV(reset_INV), .spi_clk(spi_clk),
        .spi_mosi(spi_mosi), .spi_cs_INV(spi_cs_INV), .spi_miso(spi_miso),
        .stat(stat), .ctrl(ctrl), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .frame_err(frame_err)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) begin
        if (wr_strobe === 1'b1) ws_cnt <= ws_cnt + 1;
        if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Host samples MISO on each SCLK rise; bits beyond 16 shift zeros
    task automatic spi_frame(input logic [15:0] word, input int nbits,
                             output logic [7:0] c_rx, output logic [7:0] d_rx,
                             output logic [3:0] e_rx);
        c_rx = 8'h00; d_rx = 8'h00; e_rx = 4'h0;
        spi_cs_INV = 1'b0;
        #(HALF);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = (i < 16) ? word[15-i] : 1'b0;
            #(HALF);
            spi_clk = 1'b1;
            if (i < 8)       c_rx[7-i]  = spi_miso;
            else if (i < 16) d_rx[15-i] = spi_miso;
            else if (i < 20) e_rx[19-i] = spi_miso;
            #(HALF);
            spi_clk = 1'b0;
        end
        #(HALF);
        spi_cs_INV = 1'b1;
        spi_mosi   = 1'b0;
        #(GAP);
    endtask

    initial begin
        #20;
        check("rst_ctrl", ctrl, 32'h44332211);
        check("rst_miso", {31'd0, spi_miso}, 32'd0);
        check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
        check("rst_wr_addr", {25'd0, wr_addr}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        #20 reset_INV = 1'b1;
        #(GAP);

        ws0 = ws_cnt; fe0 = fe_cnt;
        spi_frame(16'h02A5, 16, cmd_rx, dat_rx, ext_rx);
        check("wr2_ctrl", ctrl, 32'h44A52211);
        check("wr2_strobes", ws_cnt - ws0, 32'd1);
        check("wr2_addr", {25'd0, wr_addr}, 32'd2);
        check("wr2_no_err", fe_cnt - fe0, 32'd0);

        ws0 = ws_cnt;
        spi_frame(16'h8200, 16, cmd_rx, dat_rx, ext_rx);
        check("rd2_data", {24'd0, dat_rx}, 32'hA5);
        check("rd2_cmd_zero", {24'd0, cmd_rx}, 32'h00);
        check("rd2_ctrl", ctrl, 32'h44A52211);
        check("rd2_no_strobe", ws_cnt - ws0, 32'd0);
        check("idle_miso", {31'd0, spi_miso}, 32'd0);

        spi_frame(16'hC100, 16, cmd_rx, dat_rx, ext_rx);
        check("rd_stat1", {24'd0, dat_rx}, 32'h3C);
        spi_frame(16'hC300, 16, cmd_rx, dat_rx, ext_rx);
        check("rd_stat3", {24'd0, dat_rx}, 32'hA5);
        spi_frame(16'hFF00, 16, cmd_rx, dat_rx, ext_rx);
        check("rd_id", {24'd0, dat_rx}, 32'hC5);
        spi_frame(16'h9000, 16, cmd_rx, dat_rx, ext_rx);
        check("rd_unmapped", {24'd0, dat_rx}, 32'h00);

        ws0 = ws_cnt;
        spi_frame(16'h4155, 16, cmd_rx, dat_rx, ext_rx);
        spi_frame(16'h7F77, 16, cmd_rx, dat_rx, ext_rx);
        check("wr_stat_no_strobe", ws_cnt - ws0, 32'd0);
        check("wr_stat_ctrl", ctrl, 32'h44A52211);
        spi_frame(16'hC100, 16, cmd_rx, dat_rx, ext_rx);
        check("stat_after_wr", {24'd0, dat_rx}, 32'h3C);
        spi_frame(16'h8000, 16, cmd_rx, dat_rx, ext_rx);
        check("rd0_after_wr", {24'd0, dat_rx}, 32'h11);

        ws0 = ws_cnt; fe0 = fe_cnt;
        spi_frame(16'h00AA, 11, cmd_rx, dat_rx, ext_rx);
        check("abort_err", fe_cnt - fe0, 32'd1);
        check("abort_no_strobe", ws_cnt - ws0, 32'd0);
        check("abort_ctrl", ctrl, 32'h44A52211);

        ws0 = ws_cnt; fe0 = fe_cnt;
        spi_frame(16'h000F, 16, cmd_rx, dat_rx, ext_rx);
        check("post_abort_ctrl", ctrl, 32'h44A5220F);
        check("post_abort_strobe", ws_cnt - ws0, 32'd1);
        check("post_abort_no_err", fe_cnt - fe0, 32'd0);

        spi_cs_INV = 1'b0;
        #(HALF);
        for (int i = 0; i < 5; i++) begin
            spi_mosi = 1'b1;
            #(HALF); spi_clk = 1'b1;
            #(HALF); spi_clk = 1'b0;
        end
        #40 reset_INV = 1'b0;
        #30;
        check("midrst_ctrl", ctrl, 32'h44332211);
        check("midrst_miso", {31'd0, spi_miso}, 32'd0);
        check("midrst_strobe", {31'd0, wr_strobe}, 32'd0);
        check("midrst_wr_addr", {25'd0, wr_addr}, 32'd0);
        check("midrst_err", {31'd0, frame_err}, 32'd0);
        spi_cs_INV = 1'b1;
        spi_mosi   = 1'b0;
        #40 reset_INV = 1'b1;
        #(GAP);

        ws0 = ws_cnt; fe0 = fe_cnt;
        spi_frame(16'h0133, 20, cmd_rx, dat_rx, ext_rx);
        check("long_ctrl1", {24'd0, ctrl[15:8]}, 32'h33);
        check("long_ctrl", ctrl, 32'h44333311);
        check("long_strobe", ws_cnt - ws0, 32'd1);
        check("long_no_err", fe_cnt - fe0, 32'd0);
        check("long_extra_miso", {28'd0, ext_rx}, 32'd0);
        check("long_wr_addr", {25'd0, wr_addr}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
